// File: rtl/i2c_ram_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2c_ram_arbiter_pkg                                             |
// | Purpose  : Shared definitions for the I2C / menu RAM port arbiter:         |
// |            FSM state encodings and requester identifiers.                  |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package i2c_ram_arbiter_pkg;

  // Arbiter FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_CLEAR  = 2'd3;

  // Requester identifiers (who owns the access currently in flight)
  localparam logic REQ_I2C  = 1'b0;
  localparam logic REQ_MENU = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_WAIT   = ST_WAIT,
    S_CLEAR  = ST_CLEAR
  } state_e;

endpackage : i2c_ram_arbiter_pkg
`default_nettype wire

// File: rtl/i2c_ram_clear_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2c_ram_clear_seq                                               |
// | Purpose  : Address sequencer for the bulk clear sweep. Once started it     |
// |            walks addresses 0..CLEAR_DEPTH-1, one per cycle, then pulses    |
// |            done for one cycle.                                             |
// | Ports    : clk, reset (async, active-low)                                  |
// |            start  - begin a sweep (from the arbiter FSM)                   |
// |            busy   - sweep in progress                                      |
// |            last   - current cycle issues the final address                 |
// |            addr   - current sweep address                                  |
// |            done   - one-cycle pulse after the final address                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module i2c_ram_clear_seq #(
  parameter int ADDR_W      = 8,
  parameter int CLEAR_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              last,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  // Counter only needs to reach CLEAR_DEPTH-1, so it never wraps mid-sweep.
  localparam int c_cnt_w = (CLEAR_DEPTH > 1) ? $clog2(CLEAR_DEPTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLEAR_DEPTH - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_cnt == c_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end
    end
  end

  assign busy = r_busy;
  assign last = r_busy && (r_cnt == c_last);
  assign addr = ADDR_W'(r_cnt);
  assign done = r_done;

endmodule : i2c_ram_clear_seq
`default_nettype wire

// File: rtl/i2c_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2c_ram_arbiter                                                 |
// | Purpose  : Shares one synchronous RAM port between the I2C slave path and  |
// |            the menu controller, and runs a bulk clear sweep on request.    |
// |            Each access is IDLE -> ACCESS -> WAIT (3 cycles).               |
// | Ports    : clk, reset (async, active-low)                                  |
// |            i2c_*   - I2C requester: req/we/addr/wdata in, ack/rdata/rvalid |
// |            menu_*  - menu requester, same shape as i2c_*                   |
// |            clear_req in, clear_busy/clear_done out                         |
// |            ram_*   - RAM port: en/we/addr/wdata out, rdata in (1-cycle)    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module i2c_ram_arbiter
  import i2c_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int CLEAR_DEPTH = 32,
  parameter int MAX_I2C_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_req,
  input  logic              i2c_we,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic              i2c_ack,
  output logic [DATA_W-1:0] i2c_rdata,
  output logic              i2c_rvalid,
  input  logic              menu_req,
  input  logic              menu_we,
  input  logic [ADDR_W-1:0] menu_addr,
  input  logic [DATA_W-1:0] menu_wdata,
  output logic              menu_ack,
  output logic [DATA_W-1:0] menu_rdata,
  output logic              menu_rvalid,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int c_run_w = $clog2(MAX_I2C_RUN + 1);
  localparam logic [c_run_w-1:0] c_run_max = c_run_w'(MAX_I2C_RUN);

  state_e              r_state, w_next;
  logic                r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_run_w-1:0]  r_run;
  logic                r_clear_pend;
  logic [DATA_W-1:0]   r_i2c_rdata, r_menu_rdata;
  logic                r_i2c_rvalid, r_menu_rvalid;

  logic                w_grant_i2c, w_grant_menu, w_start_clear;
  logic                w_clr_busy, w_clr_last, w_clr_done;
  logic [ADDR_W-1:0]   w_clr_addr;

  i2c_ram_clear_seq #(
    .ADDR_W      (ADDR_W),
    .CLEAR_DEPTH (CLEAR_DEPTH)
  ) u_clear_seq (
    .clk   (clk),
    .reset (reset),
    .start (w_start_clear),
    .busy  (w_clr_busy),
    .last  (w_clr_last),
    .addr  (w_clr_addr),
    .done  (w_clr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state, grant decisions and RAM port drive.
  always_comb begin
    w_next        = r_state;
    w_grant_i2c   = 1'b0;
    w_grant_menu  = 1'b0;
    w_start_clear = 1'b0;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = r_addr;
    ram_wdata     = r_wdata;
    i2c_ack       = 1'b0;
    menu_ack      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // clear_req seen this cycle counts as pending so a sweep starts promptly
        if (r_clear_pend || clear_req) begin
          w_start_clear = 1'b1;
          w_next        = S_CLEAR;
        end else if (menu_req && (!i2c_req || (r_run == c_run_max))) begin
          // menu wins when alone, or when I2C has used up its run allowance
          w_grant_menu = 1'b1;
          w_next       = S_ACCESS;
        end else if (i2c_req) begin
          w_grant_i2c = 1'b1;
          w_next      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ram_en   = 1'b1;
        ram_we   = r_we;
        i2c_ack  = (r_owner == REQ_I2C);
        menu_ack = (r_owner == REQ_MENU);
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        w_next = S_IDLE;
      end
      S_CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = w_clr_addr;
        ram_wdata = '0;
        if (w_clr_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Winner capture, run counter, clear-pending flag and read-data return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner       <= REQ_I2C;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_run         <= '0;
      r_clear_pend  <= 1'b0;
      r_i2c_rdata   <= '0;
      r_menu_rdata  <= '0;
      r_i2c_rvalid  <= 1'b0;
      r_menu_rvalid <= 1'b0;
    end else begin
      r_i2c_rvalid  <= 1'b0;
      r_menu_rvalid <= 1'b0;

      if (w_grant_i2c) begin
        r_owner <= REQ_I2C;
        r_we    <= i2c_we;
        r_addr  <= i2c_addr;
        r_wdata <= i2c_wdata;
        if (!menu_req)              r_run <= '0;
        else if (r_run != c_run_max) r_run <= r_run + c_run_w'(1);
      end else if (w_grant_menu) begin
        r_owner <= REQ_MENU;
        r_we    <= menu_we;
        r_addr  <= menu_addr;
        r_wdata <= menu_wdata;
        r_run   <= '0;
      end

      // Requests made during a sweep are dropped, not queued for a second one.
      if (w_start_clear)
        r_clear_pend <= 1'b0;
      else if (clear_req && (r_state != S_CLEAR))
        r_clear_pend <= 1'b1;

      // RAM read data is valid during WAIT; capture it on the way out.
      if ((r_state == S_WAIT) && !r_we) begin
        if (r_owner == REQ_I2C) begin
          r_i2c_rdata  <= ram_rdata;
          r_i2c_rvalid <= 1'b1;
        end else begin
          r_menu_rdata  <= ram_rdata;
          r_menu_rvalid <= 1'b1;
        end
      end
    end
  end

  assign i2c_rdata   = r_i2c_rdata;
  assign i2c_rvalid  = r_i2c_rvalid;
  assign menu_rdata  = r_menu_rdata;
  assign menu_rvalid = r_menu_rvalid;
  assign clear_busy  = w_clr_busy;
  assign clear_done  = w_clr_done;

endmodule : i2c_ram_arbiter
`default_nettype wire
